ntt_stage_scheduler: RTL and testbench
======================================

# ntt_stage_scheduler

Sequences one complete NTT pass (N=2048, 64 butterfly lanes) over the shared butterfly array and ping-pong coefficient banks. It issues a fixed-length 128-cycle read window per stage, then waits a drain gap for the butterfly pipeline to flush. It generates the matching delayed write window and flips the bank select between stages. It sits between the top-level command interface and the memory/twiddle address logic, and replaces free-running per-stage counters with one scheduler that owns stage ordering.

## Interface
- STAGES, 11: number of NTT stages per pass (log2 N).
- STAGE_LEN, 128: read cycles per stage; power of two.
- DRAIN, 8: butterfly pipeline latency in cycles; legal range 1 to STAGE_LEN.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_start  input  1  one-cycle pass request; honoured only in IDLE.
- busy  output  1  high from the first RUN cycle through the DONE cycle.
- stage_start  output  1  one-cycle pulse on the first RUN cycle of each stage.
- stage_idx  output  $clog2(STAGES)  current stage number.
- rd_en  output  1  read window active (RUN state).
- rd_idx  output  $clog2(STAGE_LEN)  read cycle index within the stage.
- wr_en  output  1  rd_en delayed by exactly DRAIN cycles.
- wr_idx  output  $clog2(STAGE_LEN)  rd_idx delayed by exactly DRAIN cycles.
- bank_sel  output  1  source bank for reads; writes target !bank_sel.
- done  output  1  one-cycle pulse when the pass completes.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_start=1 moves to RUN. rd_idx loads 0, stage_idx loads the first stage, stage_start pulses.
- RUN: rd_en=1 and rd_idx increments by 1 each cycle. After the rd_idx=STAGE_LEN-1 cycle, go to DRAIN.
- DRAIN: rd_en=0 and rd_idx holds 0. Counts DRAIN cycles, covering the tail of the write window.
- At the end of DRAIN:
  - If this was not the last stage: bank_sel toggles, stage_idx advances, and the FSM re-enters RUN with stage_start pulsed.
  - If this was the last stage: go to DONE.
- DONE: done=1 for one cycle, then IDLE. bank_sel does not toggle on pass exit.
- The write delay line is a DRAIN-deep shift register of {rd_en, rd_idx}. It clears on rst only, never on a state change.
- in_start while busy is ignored. A pass is never restarted or queued.
- Reset values: state IDLE, all outputs 0, stage_idx 0, bank_sel 0, delay line cleared.
- rst mid-pass aborts immediately. The next cycle shows reset values and no done pulse.
- Counters are sized by $clog2 and compared exactly against STAGE_LEN-1, DRAIN-1 and STAGES-1. rd_idx never wraps past STAGE_LEN-1 within a stage.

## Timing
- in_start sampled high at edge t, so the first RUN cycle is t+1.
- Stage k (0-based) RUN occupies t+1+k·(STAGE_LEN+DRAIN) through t+k·(STAGE_LEN+DRAIN)+STAGE_LEN.
- wr_en for stage k spans t+1+DRAIN+k·(STAGE_LEN+DRAIN) through the last DRAIN cycle of stage k. Writes finish before the next stage's bank flip.
- done is high at cycle t+STAGES·(STAGE_LEN+DRAIN)+1. With defaults that is t+1497.
- busy falls the cycle after done. in_start in that cycle starts a new pass.

## Configuration
- NTT_SCHED_INVERSE_EN defined: adds input port in_inverse (1 bit), sampled together with in_start.
  - in_inverse=1: stage_idx runs STAGES-1 down to 0 (INTT ordering).
  - in_inverse=0: stage_idx runs 0 up to STAGES-1.
  - The sampled direction is held for the whole pass.
- Undefined: no in_inverse port; stage_idx always ascends. All timing is identical in both builds.

## Test plan
- Reset, then idle for 20 cycles -> every output stays 0 and busy stays 0.
- in_start at cycle 10, defaults -> stage_start at cycle 11, rd_idx=127 at cycle 138, wr_en first high at cycle 19, stage_idx=1 and bank_sel=1 at cycle 147, done at cycle 1507.
- in_start pulsed again at cycles 50 and 1506 during a pass -> no effect; the pass still completes at cycle 1507 with exactly 11 stage_start pulses.
- rst asserted at cycle 600 mid-pass -> cycle 601 shows reset values, wr_en stays 0, no done; a following in_start yields a full pass.
- Back-to-back passes, with in_start in the cycle after done -> second pass has stage_start 1 cycle later and bank_sel restarting at its pass-1 final value.
- With NTT_SCHED_INVERSE_EN and in_inverse=1 -> stage_idx sequence 10,9,…,0; done timing matches the forward pass.

Source files
------------

// File: rtl/ntt_stage_scheduler_if.sv
// Command/status and read/write window bundle between the NTT stage scheduler and its neighbours.
// The optional in_inverse line exists only when NTT_SCHED_INVERSE_EN is defined.
interface ntt_stage_scheduler_if #(
    parameter int STAGES    = 11,
    parameter int STAGE_LEN = 128
);
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int RW = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;

    logic          in_start;
`ifdef NTT_SCHED_INVERSE_EN
    logic          in_inverse;
`endif
    logic          busy;
    logic          stage_start;
    logic [SW-1:0] stage_idx;
    logic          rd_en;
    logic [RW-1:0] rd_idx;
    logic          wr_en;
    logic [RW-1:0] wr_idx;
    logic          bank_sel;
    logic          done;

    modport master (
        output in_start,
`ifdef NTT_SCHED_INVERSE_EN
        output in_inverse,
`endif
        input  busy, stage_start, stage_idx, rd_en, rd_idx,
        input  wr_en, wr_idx, bank_sel, done
    );

    modport slave (
        input  in_start,
`ifdef NTT_SCHED_INVERSE_EN
        input  in_inverse,
`endif
        output busy, stage_start, stage_idx, rd_en, rd_idx,
        output wr_en, wr_idx, bank_sel, done
    );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Sequences one NTT pass: per stage a STAGE_LEN-cycle read window, a DRAIN-cycle flush gap,
// a DRAIN-delayed write window and a bank flip. NTT_SCHED_INVERSE_EN adds descending stage order.
module ntt_stage_scheduler #(
    parameter int STAGES    = 11,
    parameter int STAGE_LEN = 128,
    parameter int DRAIN     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ntt_stage_scheduler_if.slave   bus
);
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int RW = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);
    localparam logic [RW-1:0] RD_LAST    = RW'(STAGE_LEN - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          stage_start_q;
    logic [SW-1:0] stage_idx_q;
    logic          rd_en_q;
    logic [RW-1:0] rd_idx_q;
    logic          bank_sel_q;
    logic          done_q;
    logic          dir_q;
    logic [DW-1:0] drain_cnt_q;
    logic [RW:0]   dly_q [DRAIN];

    logic          start_dir;
    logic [SW-1:0] stage_first_d;
    logic [SW-1:0] stage_next_d;
    logic          last_stage;

`ifdef NTT_SCHED_INVERSE_EN
    assign start_dir = bus.in_inverse;
`else
    assign start_dir = 1'b0;
`endif

    // dir_q=1 walks the stages downward (INTT ordering), otherwise upward.
    assign stage_first_d = start_dir ? STAGE_LAST : '0;
    assign stage_next_d  = dir_q ? (stage_idx_q - SW'(1)) : (stage_idx_q + SW'(1));
    assign last_stage    = dir_q ? (stage_idx_q == '0) : (stage_idx_q == STAGE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            stage_start_q <= 1'b0;
            stage_idx_q   <= '0;
            rd_en_q       <= 1'b0;
            rd_idx_q      <= '0;
            bank_sel_q    <= 1'b0;
            done_q        <= 1'b0;
            dir_q         <= 1'b0;
            drain_cnt_q   <= '0;
        end else begin
            stage_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_start) begin
                        state_q       <= S_RUN;
                        busy_q        <= 1'b1;
                        stage_start_q <= 1'b1;
                        rd_en_q       <= 1'b1;
                        rd_idx_q      <= '0;
                        stage_idx_q   <= stage_first_d;
                        dir_q         <= start_dir;
                    end
                end
                S_RUN: begin
                    if (rd_idx_q == RD_LAST) begin
                        state_q     <= S_DRAIN;
                        rd_en_q     <= 1'b0;
                        rd_idx_q    <= '0;
                        drain_cnt_q <= '0;
                    end else begin
                        rd_idx_q <= rd_idx_q + RW'(1);
                    end
                end
                S_DRAIN: begin
                    // The write window ends on the last drain cycle, so flipping banks here is safe.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (last_stage) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_RUN;
                            bank_sel_q    <= ~bank_sel_q;
                            stage_idx_q   <= stage_next_d;
                            stage_start_q <= 1'b1;
                            rd_en_q       <= 1'b1;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write-side delay line; deliberately untouched by state changes so the tail always lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DRAIN; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= {rd_en_q, rd_idx_q};
            for (int i = 1; i < DRAIN; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.stage_start = stage_start_q;
    assign bus.stage_idx   = stage_idx_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_idx      = rd_idx_q;
    assign bus.wr_en       = dly_q[DRAIN-1][RW];
    assign bus.wr_idx      = dly_q[DRAIN-1][RW-1:0];
    assign bus.bank_sel    = bank_sel_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Self-checking bench for ntt_stage_scheduler: timing-formula model plus scoreboards for
// stage_start, done and the delayed write window.
module tb_ntt_stage_scheduler;
    localparam int STAGES    = 11;
    localparam int STAGE_LEN = 128;
    localparam int DRAIN     = 8;
    localparam int PER       = STAGE_LEN + DRAIN;
    localparam int SW        = $clog2(STAGES);
    localparam int RW        = $clog2(STAGE_LEN);

    typedef struct {
        int t;
        int idx;
        bit bank;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    ev_t  ssq[$];
    ev_t  dq[$];
    ev_t  wrq[$];
    int   seen_idx[$];

    bit   pass_on;
    int   pass_t;
    bit   pass_inv;
    bit   pass_bank;
    bit   bank_model;

    ntt_stage_scheduler_if #(.STAGES(STAGES), .STAGE_LEN(STAGE_LEN)) bus ();

    ntt_stage_scheduler #(
        .STAGES(STAGES),
        .STAGE_LEN(STAGE_LEN),
        .DRAIN(DRAIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One clock of checking at the negedge: formula-derived read/busy/stage values plus scoreboard pops.
    task automatic tick();
        int            off;
        int            k;
        int            r;
        bit            in_pass;
        logic          e_rd_en;
        logic [RW-1:0] e_rd_idx;
        logic          e_busy;
        logic [SW-1:0] e_sidx;
        ev_t           ev;
        @(negedge clk);
        off     = cyc - (pass_t + 1);
        in_pass = pass_on && off >= 0 && off < STAGES * PER;
        k       = in_pass ? off / PER : 0;
        r       = in_pass ? off % PER : 0;
        e_rd_en  = in_pass && r < STAGE_LEN;
        e_rd_idx = e_rd_en ? RW'(r) : '0;
        e_busy   = pass_on && off >= 0 && off <= STAGES * PER;

        checks++;
        if (bus.rd_en !== e_rd_en || bus.rd_idx !== e_rd_idx) begin
            failures++;
            $display("[TB] FAIL rd_window cyc=%0d got en=%0b idx=%0d exp en=%0b idx=%0d",
                     cyc, bus.rd_en, bus.rd_idx, e_rd_en, e_rd_idx);
        end
        checks++;
        if (bus.busy !== e_busy) begin
            failures++;
            $display("[TB] FAIL busy cyc=%0d got=%0b exp=%0b", cyc, bus.busy, e_busy);
        end
        if (in_pass) begin
            e_sidx = pass_inv ? SW'(STAGES - 1 - k) : SW'(k);
            checks++;
            if (bus.stage_idx !== e_sidx || bus.bank_sel !== (pass_bank ^ k[0])) begin
                failures++;
                $display("[TB] FAIL stage_state cyc=%0d got idx=%0d bank=%0b exp idx=%0d bank=%0b",
                         cyc, bus.stage_idx, bus.bank_sel, e_sidx, pass_bank ^ k[0]);
            end
        end

        checks++;
        if (ssq.size() > 0 && ssq[0].t == cyc) begin
            ev = ssq.pop_front();
            if (bus.stage_start !== 1'b1 || bus.stage_idx !== SW'(ev.idx) || bus.bank_sel !== ev.bank) begin
                failures++;
                $display("[TB] FAIL stage_start_ev cyc=%0d got ss=%0b idx=%0d bank=%0b exp ss=1 idx=%0d bank=%0b",
                         cyc, bus.stage_start, bus.stage_idx, bus.bank_sel, ev.idx, ev.bank);
            end
        end else if (bus.stage_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stage_start_idle cyc=%0d got=%0b exp=0", cyc, bus.stage_start);
        end

        checks++;
        if (dq.size() > 0 && dq[0].t == cyc) begin
            ev = dq.pop_front();
            if (bus.done !== 1'b1) begin
                failures++;
                $display("[TB] FAIL done_ev cyc=%0d got=%0b exp=1", cyc, bus.done);
            end
        end else if (bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_idle cyc=%0d got=%0b exp=0", cyc, bus.done);
        end

        checks++;
        if (wrq.size() > 0 && wrq[0].t == cyc) begin
            ev = wrq.pop_front();
            if (bus.wr_en !== 1'b1 || bus.wr_idx !== RW'(ev.idx)) begin
                failures++;
                $display("[TB] FAIL wr_window cyc=%0d got en=%0b idx=%0d exp en=1 idx=%0d",
                         cyc, bus.wr_en, bus.wr_idx, ev.idx);
            end
        end else if (bus.wr_en !== 1'b0 || bus.wr_idx !== '0) begin
            failures++;
            $display("[TB] FAIL wr_idle cyc=%0d got en=%0b idx=%0d exp en=0 idx=0",
                     cyc, bus.wr_en, bus.wr_idx);
        end

        if (e_rd_en) begin
            ev.t = cyc + DRAIN; ev.idx = int'(e_rd_idx); ev.bank = 1'b0;
            wrq.push_back(ev);
        end
    endtask

    // Drives in_start for the current cycle and pushes the expected pass events.
    task automatic start_pass(input bit inv, output int t);
        ev_t ev;
        bus.in_start = 1'b1;
`ifdef NTT_SCHED_INVERSE_EN
        bus.in_inverse = inv;
`endif
        t         = cyc;
        pass_t    = t;
        pass_on   = 1'b1;
        pass_inv  = inv;
        pass_bank = bank_model;
        bank_model = bank_model ^ 1'((STAGES - 1) & 1);
        for (int k = 0; k < STAGES; k++) begin
            ev.t    = t + 1 + k * PER;
            ev.idx  = inv ? STAGES - 1 - k : k;
            ev.bank = pass_bank ^ 1'(k & 1);
            ssq.push_back(ev);
        end
        ev.t = t + 1 + STAGES * PER; ev.idx = 0; ev.bank = 1'b0;
        dq.push_back(ev);
    endtask

    task automatic apply_reset_now();
        rst     = 1'b1;
        pass_on = 1'b0;
        bank_model = 1'b0;
        ssq.delete();
        dq.delete();
        wrq.delete();
    endtask

    // Runs from the start cycle through the done cycle, pulsing in_start at p1/p2.
    task automatic run_to_done(input int t, input int p1, input int p2,
                               output int ns, output int done_cyc, output int first_ss);
        ns = 0; done_cyc = -1; first_ss = -1;
        seen_idx.delete();
        for (int i = 1; i <= STAGES * PER + 1; i++) begin
            tick();
            bus.in_start = (cyc == p1 || cyc == p2);
            if (bus.stage_start === 1'b1) begin
                ns++;
                seen_idx.push_back(int'(bus.stage_idx));
                if (first_ss < 0) first_ss = cyc;
            end
            if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
        bus.in_start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset_now();
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.stage_start !== 1'b0 || bus.stage_idx !== '0 ||
                bus.rd_en !== 1'b0 || bus.rd_idx !== '0 || bus.wr_en !== 1'b0 ||
                bus.wr_idx !== '0 || bus.bank_sel !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle cyc=%0d got busy=%0b ss=%0b sidx=%0d rd=%0b/%0d wr=%0b/%0d bank=%0b done=%0b exp all 0",
                         cyc, bus.busy, bus.stage_start, bus.stage_idx, bus.rd_en, bus.rd_idx,
                         bus.wr_en, bus.wr_idx, bus.bank_sel, bus.done);
            end
        end
    endtask

    task automatic test_single_pass();
        int t;
        int ns;
        ns = 0;
        start_pass(1'b0, t);
        for (int i = 1; i <= STAGES * PER + 1; i++) begin
            tick();
            bus.in_start = 1'b0;
            if (bus.stage_start === 1'b1) ns++;
            if (cyc == t + 1) begin
                checks++;
                if (bus.stage_start !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL first_stage_start got=%0b exp=1", bus.stage_start);
                end
            end
            if (cyc == t + STAGE_LEN) begin
                checks++;
                if (bus.rd_idx !== RW'(STAGE_LEN - 1) || bus.rd_en !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL last_rd_idx got=%0d exp=%0d", bus.rd_idx, STAGE_LEN - 1);
                end
            end
            if (cyc == t + DRAIN || cyc == t + DRAIN + 1) begin
                checks++;
                if (bus.wr_en !== 1'(cyc == t + DRAIN + 1)) begin
                    failures++;
                    $display("[TB] FAIL wr_en_edge cyc=%0d got=%0b exp=%0b", cyc, bus.wr_en, cyc == t + DRAIN + 1);
                end
            end
            if (cyc == t + 1 + PER) begin
                checks++;
                if (bus.stage_idx !== SW'(1) || bus.bank_sel !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL stage1_flip got idx=%0d bank=%0b exp idx=1 bank=1", bus.stage_idx, bus.bank_sel);
                end
            end
            if (cyc == t + STAGES * PER + 1) begin
                checks++;
                if (bus.done !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL done_time got=%0b exp=1", bus.done);
                end
            end
        end
        checks++;
        if (ns != STAGES) begin
            failures++;
            $display("[TB] FAIL single_stage_count got=%0d exp=%0d", ns, STAGES);
        end
    endtask

    task automatic test_ignored_start();
        int t, ns, dc, fs;
        start_pass(1'b0, t);
        run_to_done(t, t + 40, t + STAGES * PER - 1, ns, dc, fs);
        checks++;
        if (ns != STAGES || dc != t + STAGES * PER + 1) begin
            failures++;
            $display("[TB] FAIL ignored_start got stages=%0d done=%0d exp stages=%0d done=%0d",
                     ns, dc, STAGES, t + STAGES * PER + 1);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_after_done got=%0b exp=0", bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        int t, ns, dc, fs;
        start_pass(1'b0, t);
        for (int i = 1; i <= 590; i++) begin
            tick();
            bus.in_start = 1'b0;
        end
        apply_reset_now();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.stage_idx !== '0 || bus.rd_en !== 1'b0 || bus.rd_idx !== '0 ||
            bus.wr_en !== 1'b0 || bus.bank_sel !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_values got busy=%0b sidx=%0d rd=%0b wr=%0b bank=%0b done=%0b exp all 0",
                     bus.busy, bus.stage_idx, bus.rd_en, bus.wr_en, bus.bank_sel, bus.done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_reset_quiet cyc=%0d got wr=%0b done=%0b exp 0", cyc, bus.wr_en, bus.done);
            end
        end
        start_pass(1'b0, t);
        run_to_done(t, -1, -1, ns, dc, fs);
        checks++;
        if (ns != STAGES || dc != t + STAGES * PER + 1) begin
            failures++;
            $display("[TB] FAIL pass_after_reset got stages=%0d done=%0d exp stages=%0d done=%0d",
                     ns, dc, STAGES, t + STAGES * PER + 1);
        end
    endtask

    task automatic test_back_to_back();
        int  t1, t2, ns, dc, fs;
        bit  exp_bank;
        start_pass(1'b0, t1);
        run_to_done(t1, -1, -1, ns, dc, fs);
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_gap got busy=%0b done=%0b exp 0", bus.busy, bus.done);
        end
        exp_bank = bank_model;
        start_pass(1'b0, t2);
        tick();
        checks++;
        if (cyc != t1 + STAGES * PER + 3 || bus.stage_start !== 1'b1 || bus.bank_sel !== exp_bank) begin
            failures++;
            $display("[TB] FAIL b2b_restart cyc=%0d got ss=%0b bank=%0b exp cyc=%0d ss=1 bank=%0b",
                     cyc, bus.stage_start, bus.bank_sel, t1 + STAGES * PER + 3, exp_bank);
        end
        bus.in_start = 1'b0;
        for (int i = 2; i <= STAGES * PER + 1; i++) tick();
        checks++;
        if (bus.done !== 1'b1 || cyc != t2 + STAGES * PER + 1) begin
            failures++;
            $display("[TB] FAIL b2b_second_done cyc=%0d got=%0b exp=1", cyc, bus.done);
        end
    endtask

`ifdef NTT_SCHED_INVERSE_EN
    task automatic test_inverse();
        int t, ns, dc, fs;
        bit ok;
        tick();
        start_pass(1'b1, t);
        run_to_done(t, -1, -1, ns, dc, fs);
        bus.in_inverse = 1'b0;
        ok = (seen_idx.size() == STAGES);
        for (int i = 0; i < seen_idx.size(); i++) begin
            if (seen_idx[i] != STAGES - 1 - i) ok = 1'b0;
        end
        checks++;
        if (!ok || dc != t + STAGES * PER + 1) begin
            failures++;
            $display("[TB] FAIL inverse_order got stages=%0d done=%0d exp descending %0d stages done=%0d",
                     seen_idx.size(), dc, STAGES, t + STAGES * PER + 1);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        pass_on      = 1'b0;
        pass_t       = 0;
        pass_inv     = 1'b0;
        pass_bank    = 1'b0;
        bank_model   = 1'b0;
        rst          = 1'b1;
        bus.in_start = 1'b0;
`ifdef NTT_SCHED_INVERSE_EN
        bus.in_inverse = 1'b0;
`endif
        $display("[TB] starting ntt_stage_scheduler bench");
        test_reset();
        test_single_pass();
        repeat (5) tick();
        test_ignored_start();
        test_mid_reset();
        repeat (3) tick();
        test_back_to_back();
`ifdef NTT_SCHED_INVERSE_EN
        test_inverse();
`endif
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
